// File: rtl/fifo_lane_8bits.sv
// Synchronous 4-deep FIFO buffering one output lane of the 1x2 byte demux.
// Optional FIFO_DROP_COUNT_EN builds a saturating counter of dropped pushes.
module fifo_lane_8bits #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 2,
    parameter int unsigned AF_THRESH  = 3,
    parameter int unsigned AE_THRESH  = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  overflow_err,
    output logic                  underflow_err,
    output logic [7:0]            drop_count
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam int unsigned CW    = ADDR_WIDTH + 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  valid_out_q, valid_out_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic                  almost_full_q, almost_full_d;
    logic                  almost_empty_q, almost_empty_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic                  pop_ok;
    logic                  wr_ok;

    // Access decode and next-state; flags are recomputed from the next count
    // so their registered copies always match the registered count.
    always_comb begin
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        data_out_d     = data_out_q;
        valid_out_d    = 1'b0;
        overflow_d     = overflow_q;
        underflow_d    = underflow_q;

        pop_ok = pop && !empty_q;
        wr_ok  = push && (!full_q || pop_ok);

        if (wr_ok) begin
            wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
        end
        if (pop_ok) begin
            rd_ptr_d    = rd_ptr_q + ADDR_WIDTH'(1);
            data_out_d  = mem_q[rd_ptr_q];
            valid_out_d = 1'b1;
        end
        if (push && !wr_ok) begin
            overflow_d = 1'b1;
        end
        if (pop && !pop_ok) begin
            underflow_d = 1'b1;
        end

        count_d        = count_q + CW'(wr_ok) - CW'(pop_ok);
        full_d         = (count_d == CW'(DEPTH));
        empty_d        = (count_d == '0);
        almost_full_d  = (count_d >= CW'(AF_THRESH));
        almost_empty_d = (count_d <= CW'(AE_THRESH));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            data_out_q     <= '0;
            valid_out_q    <= 1'b0;
            full_q         <= 1'b0;
            empty_q        <= 1'b1;
            almost_full_q  <= 1'b0;
            almost_empty_q <= 1'b1;
            overflow_q     <= 1'b0;
            underflow_q    <= 1'b0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            data_out_q     <= data_out_d;
            valid_out_q    <= valid_out_d;
            full_q         <= full_d;
            empty_q        <= empty_d;
            almost_full_q  <= almost_full_d;
            almost_empty_q <= almost_empty_d;
            overflow_q     <= overflow_d;
            underflow_q    <= underflow_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

`ifdef FIFO_DROP_COUNT_EN
    logic [7:0] drop_q, drop_d;

    always_comb begin
        drop_d = drop_q;
        if (push && !wr_ok && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_q <= '0;
        end else begin
            drop_q <= drop_d;
        end
    end

    assign drop_count = drop_q;
`else
    assign drop_count = 8'h00;
`endif

    assign data_out      = data_out_q;
    assign valid_out     = valid_out_q;
    assign full          = full_q;
    assign empty         = empty_q;
    assign almost_full   = almost_full_q;
    assign almost_empty  = almost_empty_q;
    assign overflow_err  = overflow_q;
    assign underflow_err = underflow_q;

endmodule

// File: tb/tb_fifo_lane_8bits.sv
// Directed scoreboard bench for fifo_lane_8bits; follows FIFO_DROP_COUNT_EN like the RTL.
module tb_fifo_lane_8bits;

    logic       clk = 1'b0;
    logic       reset;
    logic       push;
    logic       pop;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       valid_out;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic       overflow_err;
    logic       underflow_err;
    logic [7:0] drop_count;

    fifo_lane_8bits dut (
        .clk          (clk),
        .reset        (reset),
        .push         (push),
        .data_in      (data_in),
        .pop          (pop),
        .data_out     (data_out),
        .valid_out    (valid_out),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .overflow_err (overflow_err),
        .underflow_err(underflow_err),
        .drop_count   (drop_count)
    );

    always #5 clk = ~clk;

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] sb[$];
    int         m_cnt;
    logic       m_valid;
    logic       m_ovf;
    logic       m_unf;
    logic [7:0] m_last;
    logic [7:0] m_drop;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".valid_out"},     32'(valid_out),     32'(m_valid));
        chk({tag, ".data_out"},      32'(data_out),      32'(m_last));
        chk({tag, ".full"},          32'(full),          32'(m_cnt == 4));
        chk({tag, ".empty"},         32'(empty),         32'(m_cnt == 0));
        chk({tag, ".almost_full"},   32'(almost_full),   32'(m_cnt >= 3));
        chk({tag, ".almost_empty"},  32'(almost_empty),  32'(m_cnt <= 1));
        chk({tag, ".overflow_err"},  32'(overflow_err),  32'(m_ovf));
        chk({tag, ".underflow_err"}, 32'(underflow_err), 32'(m_unf));
        chk({tag, ".drop_count"},    32'(drop_count),    32'(m_drop));
    endtask

    task automatic model_reset();
        sb.delete();
        m_cnt   = 0;
        m_valid = 1'b0;
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
        m_last  = 8'h00;
        m_drop  = 8'h00;
    endtask

    // One clock of stimulus; expected data queued on accepted writes, dequeued on output.
    task automatic step(input string tag, input logic p, input logic [7:0] d, input logic r);
        logic pop_ok;
        logic wr_ok;
        push    = p;
        data_in = d;
        pop     = r;
        pop_ok  = r && (m_cnt != 0);
        wr_ok   = p && ((m_cnt != 4) || pop_ok);
        if (wr_ok) sb.push_back(d);
        m_cnt   = m_cnt + int'(wr_ok) - int'(pop_ok);
        m_valid = pop_ok;
        if (p && !wr_ok) m_ovf = 1'b1;
        if (r && !pop_ok) m_unf = 1'b1;
`ifdef FIFO_DROP_COUNT_EN
        if (p && !wr_ok && (m_drop != 8'hFF)) m_drop = m_drop + 8'd1;
`endif
        @(posedge clk);
        #1;
        if (m_valid) m_last = sb.pop_front();
        push = 1'b0;
        pop  = 1'b0;
        check_all(tag);
    endtask

    initial begin
        reset   = 1'b1;
        push    = 1'b0;
        pop     = 1'b0;
        data_in = 8'h00;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        reset = 1'b0;

        step("t1_push_a1", 1'b1, 8'hA1, 1'b0);
        step("t1_push_b2", 1'b1, 8'hB2, 1'b0);
        step("t1_push_c3", 1'b1, 8'hC3, 1'b0);

        step("t2_pop0", 1'b0, 8'h00, 1'b1);
        step("t2_pop1", 1'b0, 8'h00, 1'b1);
        step("t2_pop2", 1'b0, 8'h00, 1'b1);
        step("t2_idle", 1'b0, 8'h00, 1'b0);

        step("t3_fill0", 1'b1, 8'h11, 1'b0);
        step("t3_fill1", 1'b1, 8'h22, 1'b0);
        step("t3_fill2", 1'b1, 8'h33, 1'b0);
        step("t3_fill3", 1'b1, 8'h44, 1'b0);
        step("t3_drop",  1'b1, 8'hFF, 1'b0);

        step("t4_pushpop_full", 1'b1, 8'h55, 1'b1);
        for (int i = 0; i < 4; i++) step("t4_drain", 1'b0, 8'h00, 1'b1);
        step("t4_idle", 1'b0, 8'h00, 1'b0);

        step("t5_pop_push_empty", 1'b1, 8'h77, 1'b1);
        step("t5_pop77", 1'b0, 8'h00, 1'b1);

        step("t6_w0", 1'b1, 8'h60, 1'b0);
        for (int i = 1; i < 6; i++) step("t6_wr", 1'b1, 8'(8'h60 + i), 1'b1);
        step("t6_r5", 1'b0, 8'h00, 1'b1);
        step("t6_more0", 1'b1, 8'h9A, 1'b0);
        step("t6_more1", 1'b1, 8'h9B, 1'b1);

        // Async reset asserted between edges, with a push in flight.
        push    = 1'b1;
        data_in = 8'hEE;
        #3;
        reset = 1'b1;
        #1;
        model_reset();
        check_all("t6_midreset");
        push = 1'b0;
        @(posedge clk);
        #1;
        check_all("t6_reset_held");
        reset = 1'b0;

        step("post_push", 1'b1, 8'h3C, 1'b0);
        step("post_pop",  1'b0, 8'h00, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
